// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with loadable pattern, overlap control and match counter.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
//
// state | meaning
// FILL  | fewer than PAT_W valid history bits
// ARMED | history full, last accepted bit did not complete a match
// HIT   | last accepted bit completed a match (out=1)
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1000),
  parameter int CNT_W = 8,
  localparam int FW = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic             cnt_clear,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [FW-1:0]    fill_level
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  state_t           state_q, state_n;
  logic [PAT_W-1:0] hist_q, hist_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [FW-1:0]    fill_q, fill_n;
  logic [PAT_W-1:0] shifted;
  logic [FW-1:0]    fill_inc;
  logic             match;
  logic             out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      hist_q  <= '0;
      pat_q   <= PAT_INIT;
      fill_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      hist_q  <= hist_n;
      pat_q   <= pat_n;
      fill_q  <= fill_n;
      out_q   <= (state_n == HIT);
    end
  end

  always_comb begin
    state_n  = state_q;
    hist_n   = hist_q;
    pat_n    = pat_q;
    fill_n   = fill_q;
    match    = 1'b0;
    shifted  = {hist_q[PAT_W-2:0], in_bit};
    fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    // A pattern load takes priority and drops any bit offered in the same cycle.
    if (pat_load) begin
      pat_n   = pat_value;
      hist_n  = '0;
      fill_n  = '0;
      state_n = FILL;
    end else if (in_valid) begin
      hist_n = shifted;
      fill_n = fill_inc;
      match  = (fill_inc == FULL) && (shifted == pat_q);
      if (match) begin
        state_n = HIT;
        if (!overlap_en) fill_n = '0;
      end else if (fill_inc == FULL) begin
        state_n = ARMED;
      end else begin
        state_n = FILL;
      end
    end
  end

  assign out        = out_q;
  assign fill_level = fill_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear beats a coincident match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_clear) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus randomized traffic
// compared against a bit-queue reference model.
module tb_seq_detector_param;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int FW      = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_value;
  logic             cnt_clear;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic [FW-1:0]    fill_level;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_value  (pat_value),
    .cnt_clear  (cnt_clear),
    .out        (out),
    .match_count(match_count),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the accepted bits since the last flush (at most PAT_W kept).
  bit               q[$];
  logic [PAT_W-1:0] m_pat;
  bit               m_out;
  int               m_cnt;

  function automatic int exp_cnt();
`ifdef SEQDET_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_cnt_of(input int n);
`ifdef SEQDET_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = PAT_W'(4'b1000);
    m_out = 1'b0;
    m_cnt = 0;
  endtask

  task automatic cycle(input bit v, input bit b, input bit ovl, input bit ld,
                       input logic [PAT_W-1:0] pv, input bit clr);
    bit hit;
    in_valid = v; in_bit = b; overlap_en = ovl; pat_load = ld; pat_value = pv; cnt_clear = clr;
    @(posedge clk);
    hit = 1'b0;
    if (ld) begin
      m_pat = pv;
      q.delete();
      m_out = 1'b0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > PAT_W) void'(q.pop_front());
      if (q.size() == PAT_W) begin
        hit = 1'b1;
        for (int i = 0; i < PAT_W; i++)
          if (q[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
      end
      m_out = hit;
      if (hit && !ovl) q.delete();
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    #1;
    in_valid = 1'b0; pat_load = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bit bits[4] = '{1, 0, 0, 0};
    foreach (bits[i]) cycle(1, bits[i], 1, 0, '0, 0);
    n_vec++;
    if (out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_premise: out=%b want 1", out);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({out, fill_level, match_count} !== {1'b0, FW'(0), CNT_W'(0)}) begin
      n_err++;
      $display("FAIL reset_async: out=%b fill=%0d cnt=%0d want 0/0/0", out, fill_level, match_count);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_legacy();
    bit bits[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    logic [7:0] mask;
    do_reset();
    foreach (bits[i]) begin
      cycle(1, bits[i], 1, 0, '0, 0);
      mask[i] = out;
      n_vec++;
      if ({out, fill_level, match_count} !== {m_out, FW'(q.size()), CNT_W'(exp_cnt())}) begin
        n_err++;
        $display("FAIL legacy step %0d: got out=%b fill=%0d cnt=%0d want out=%b fill=%0d cnt=%0d",
                 i, out, fill_level, match_count, m_out, q.size(), exp_cnt());
      end
    end
    n_vec++;
    if (mask !== 8'b1000_1000 || match_count !== CNT_W'(exp_cnt_of(2))) begin
      n_err++;
      $display("FAIL legacy_pulses: mask=%b cnt=%0d want 10001000 cnt=%0d", mask, match_count, exp_cnt_of(2));
    end
  endtask

  task automatic test_overlap();
    bit bits[6] = '{1, 0, 1, 0, 1, 0};
    logic [5:0] mask;
    for (int ovl = 1; ovl >= 0; ovl--) begin
      do_reset();
      cycle(0, 0, 1'(ovl), 1, 4'b1010, 0);
      foreach (bits[i]) begin
        cycle(1, bits[i], 1'(ovl), 0, '0, 0);
        mask[i] = out;
        n_vec++;
        if ({out, fill_level, match_count} !== {m_out, FW'(q.size()), CNT_W'(exp_cnt())}) begin
          n_err++;
          $display("FAIL overlap%0d step %0d: got out=%b fill=%0d cnt=%0d want out=%b fill=%0d cnt=%0d",
                   ovl, i, out, fill_level, match_count, m_out, q.size(), exp_cnt());
        end
      end
      n_vec++;
      if (mask !== (ovl ? 6'b101000 : 6'b001000) ||
          match_count !== CNT_W'(exp_cnt_of(ovl ? 2 : 1))) begin
        n_err++;
        $display("FAIL overlap%0d_pulses: mask=%b cnt=%0d want %b cnt=%0d", ovl, mask, match_count,
                 ovl ? 6'b101000 : 6'b001000, exp_cnt_of(ovl ? 2 : 1));
      end
    end
  endtask

  task automatic test_valid_gap();
    bit vs[9] = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
    bit bs[9] = '{1, 0, 0, 1, 1, 1, 0, 1, 1};
    logic [8:0] mask;
    do_reset();
    foreach (vs[i]) begin
      cycle(vs[i], bs[i], 1, 0, '0, 0);
      mask[i] = out;
      n_vec++;
      if ({out, fill_level} !== {m_out, FW'(q.size())}) begin
        n_err++;
        $display("FAIL valid_gap step %0d: got out=%b fill=%0d want out=%b fill=%0d",
                 i, out, fill_level, m_out, q.size());
      end
    end
    n_vec++;
    if (mask !== 9'b1_1100_0000) begin
      n_err++;
      $display("FAIL valid_gap_mask: got %b want 111000000", mask);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 1, 1, 0, '0, 0);
    cycle(1, 0, 1, 0, '0, 0);
    cycle(1, 0, 1, 0, '0, 0);
    do_reset();
    cycle(1, 0, 1, 0, '0, 0);
    n_vec++;
    if (out !== 1'b0 || fill_level !== FW'(1)) begin
      n_err++;
      $display("FAIL reset_mid: got out=%b fill=%0d want out=0 fill=1", out, fill_level);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int m = 0; m < 5; m++) begin
      cycle(1, 1, 1, 0, '0, 0);
      cycle(1, 0, 1, 0, '0, 0);
      cycle(1, 0, 1, 0, '0, 0);
      cycle(1, 0, 1, 0, '0, 0);
      n_vec++;
      if ({out, match_count} !== {1'b1, CNT_W'(exp_cnt_of(m + 1 > CNT_MAX ? CNT_MAX : m + 1))}) begin
        n_err++;
        $display("FAIL saturate match %0d: got out=%b cnt=%0d want out=1 cnt=%0d",
                 m + 1, out, match_count, exp_cnt_of(m + 1 > CNT_MAX ? CNT_MAX : m + 1));
      end
    end
    cycle(1, 1, 1, 0, '0, 0);
    cycle(1, 0, 1, 0, '0, 0);
    cycle(1, 0, 1, 0, '0, 0);
    cycle(1, 0, 1, 0, '0, 1);
    n_vec++;
    if ({out, match_count} !== {1'b1, CNT_W'(0)}) begin
      n_err++;
      $display("FAIL clear_wins: got out=%b cnt=%0d want out=1 cnt=0", out, match_count);
    end
  endtask

  task automatic test_load_drop();
    bit bits[4] = '{0, 1, 1, 0};
    do_reset();
    cycle(1, 1, 1, 0, '0, 0);
    cycle(1, 0, 1, 0, '0, 0);
    cycle(1, 1, 1, 1, 4'b0110, 0);
    n_vec++;
    if (out !== 1'b0 || fill_level !== FW'(0)) begin
      n_err++;
      $display("FAIL load_drop: got out=%b fill=%0d want out=0 fill=0", out, fill_level);
    end
    foreach (bits[i]) begin
      cycle(1, bits[i], 1, 0, '0, 0);
      n_vec++;
      if (out !== (i == 3 ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL load_match step %0d: got out=%b want %b", i, out, i == 3);
      end
    end
  endtask

  task automatic test_random();
    bit ovl;
    do_reset();
    ovl = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) ovl = 1'($urandom);
      if (i % 270 == 269) do_reset();
      cycle($urandom_range(0, 3) != 0, 1'($urandom), ovl, $urandom_range(0, 40) == 0,
            PAT_W'($urandom), $urandom_range(0, 30) == 0);
      n_vec++;
      if ({out, fill_level, match_count} !== {m_out, FW'(q.size()), CNT_W'(exp_cnt())}) begin
        n_err++;
        $display("FAIL random cycle %0d: got out=%b fill=%0d cnt=%0d want out=%b fill=%0d cnt=%0d",
                 i, out, fill_level, match_count, m_out, q.size(), exp_cnt());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_bit = 1'b0; overlap_en = 1'b1;
    pat_load = 1'b0; pat_value = '0; cnt_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out, fill_level, match_count} !== {1'b0, FW'(0), CNT_W'(0)}) begin
      n_err++;
      $display("FAIL power_on_reset: out=%b fill=%0d cnt=%0d want 0/0/0", out, fill_level, match_count);
    end
    reset = 1'b0;
    test_reset();
    test_legacy();
    test_overlap();
    test_valid_gap();
    test_reset_mid();
    test_saturation();
    test_load_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
